// File: rtl/td4_prog_loader_pkg.sv
// Shared definitions for the TD4 program loader and the core that fetches from it.
package td4_prog_loader_pkg;

  localparam int TD4_DEPTH = 16;
  localparam int TD4_AW    = 4;
  localparam int TD4_DW    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

  // States in which the loader is consuming bytes from the stream.
  function automatic logic accepts_bytes(input loader_state_e st);
    return (st == ST_LOAD) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/td4_prog_mem.sv
// TD4 instruction memory: one synchronous write port, one combinational read port.
module td4_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// Streams a program into the TD4 instruction memory, checks the trailing
// checksum and releases the core once the image has been accepted.
module td4_prog_loader
  import td4_prog_loader_pkg::*;
#(
  parameter int DEPTH       = TD4_DEPTH,
  parameter int AW          = TD4_AW,
  parameter int DW          = TD4_DW,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          core_run,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  loader_state_e state_r, next_state_s;
  logic [AW-1:0] wr_ptr_r, wr_ptr_s;
  logic [DW-1:0] sum_r, sum_s, check_sum_s;
  logic          we_s, fire_s;
  logic          in_ready_r, busy_r, core_run_r, done_r, err_r;

  assign fire_s      = in_valid & in_ready_r;
  assign check_sum_s = sum_r + in_data;

  // State, write pointer and running checksum registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= {AW{1'b0}};
      sum_r    <= {DW{1'b0}};
    end else begin
      state_r  <= next_state_s;
      wr_ptr_r <= wr_ptr_s;
      sum_r    <= sum_s;
    end
  end

  // Next-state logic; load_start outranks any byte presented in the same cycle.
  always_comb begin
    next_state_s = state_r;
    wr_ptr_s     = wr_ptr_r;
    sum_s        = sum_r;
    we_s         = 1'b0;
    if (load_start) begin
      next_state_s = ST_LOAD;
      wr_ptr_s     = {AW{1'b0}};
      sum_s        = {DW{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (fire_s) begin
            we_s     = 1'b1;
            sum_s    = check_sum_s;
            wr_ptr_s = wr_ptr_r + AW'(1);
            if (wr_ptr_r == LAST_PTR) begin
              if (CHECKSUM_EN) begin
                next_state_s = ST_CHECK;
              end else begin
                next_state_s = ST_RUN;
              end
            end else begin
              next_state_s = ST_LOAD;
            end
          end else begin
            next_state_s = ST_LOAD;
          end
        end
        ST_CHECK: begin
          if (fire_s) begin
            if (check_sum_s == {DW{1'b0}}) begin
              next_state_s = ST_RUN;
            end else begin
              next_state_s = ST_ERROR;
            end
          end else begin
            next_state_s = ST_CHECK;
          end
        end
        ST_IDLE, ST_RUN, ST_ERROR: next_state_s = state_r;
        default:                   next_state_s = ST_IDLE;
      endcase
    end
  end

  // Status flops track the state being entered, so they change on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      core_run_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      in_ready_r <= accepts_bytes(next_state_s);
      busy_r     <= accepts_bytes(next_state_s);
      core_run_r <= (next_state_s == ST_RUN);
      done_r     <= (next_state_s == ST_RUN);
      err_r      <= (next_state_s == ST_ERROR);
    end
  end

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign core_run = core_run_r;
  assign done     = done_r;
  assign err      = err_r;

  td4_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clock (clock),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Writer side of the TD4 16x8 instruction memory.
- Accepts a program as a byte stream over a valid/ready handshake and writes it sequentially into an internal 16-entry x 8-bit memory.
- Verifies an optional trailing checksum, then releases the core to run.
- The core reads the same memory through a combinational read port (rd_addr = ip, rd_data = instruction byte).
- Replaces the fixed-content instruction memory in the top level.

Parameters:
DEPTH, 16, number of program words (power of two)
AW, 4, address width, log2(DEPTH)
DW, 8, word width (4-bit opcode + 4-bit immediate)
CHECKSUM_EN, 1, 1 = a checksum byte must follow the last word; 0 = no checksum byte

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
load_start  in  1  single-cycle pulse; starts or restarts a program load
in_valid  in  1  in_data holds a valid byte
in_data  in  DW  program/checksum byte
in_ready  out  1  loader accepts a byte this cycle
rd_addr  in  AW  core fetch address (core ip)
rd_data  out  DW  combinational read of mem[rd_addr]
core_run  out  1  1 = core may run; drive the core's active-low reset with this
busy  out  1  load or checksum phase in progress
done  out  1  a program was loaded and accepted; core running
err  out  1  checksum mismatch on the last load

Behaviour:
- Reset is asynchronous, active-high, takes effect immediately. Reset values:
  - state=IDLE, wr_ptr=0, sum=0
  - in_ready=0, core_run=0, busy=0, done=0, err=0
  - Memory array is not cleared by reset; power-up contents are all zeros.
- All outputs except rd_data are registered. They are decoded from the state register or are flops updated on the clock edge.
- Byte transfer occurs on a rising edge with in_valid=1 and in_ready=1. in_data is ignored otherwise.
- in_ready=1 only in LOAD and CHECK.
- States:
  - IDLE: core_run=0. load_start -> LOAD, wr_ptr<=0, sum<=0.
  - LOAD: busy=1. Each transfer writes mem[wr_ptr]<=in_data, sum<=(sum+in_data) mod 2^DW, wr_ptr<=wr_ptr+1. The transfer at wr_ptr=DEPTH-1 wraps wr_ptr to 0 and goes to CHECK if CHECKSUM_EN=1, else RUN.
  - CHECK: busy=1. On transfer, (sum+in_data) mod 2^DW is evaluated. If 0 -> RUN, done<=1. Otherwise -> ERROR, err<=1. The checksum byte is not written to memory.
  - RUN: core_run=1, done=1, in_ready=0. load_start -> LOAD, which clears core_run and done and resets wr_ptr/sum.
  - ERROR: core_run=0, err=1. load_start -> LOAD and clears err.
- load_start in LOAD or CHECK restarts the load (wr_ptr<=0, sum<=0). Any transfer presented in that cycle is discarded: no memory write, no sum update. load_start has priority over the handshake.
- With CHECKSUM_EN=0: LOAD -> RUN directly, done<=1, err never set.
- core_run deasserts on the edge that enters LOAD, so the core is held in reset for the whole load. The core restarts at ip=0 when core_run rises.
- rd_data is a pure combinational read. A write to the address being read shows the new data only after the write edge.
- in_valid may stay high across cycles. One byte is consumed per edge while in_ready=1.
- No latency from the last accepted byte to core_run=1 beyond the state flop: core_run=1 on the cycle after the accepting edge.

Decomposition:
- Shared package:
  - Loader state encoding (IDLE, LOAD, CHECK, RUN, ERROR)
  - Default DEPTH/AW/DW constants, also used by the core
- Sub-module td4_prog_mem: DEPTH x DW array, one synchronous write port (we, waddr, wdata), one combinational read port.
- The FSM, pointer and checksum logic stay in td4_prog_loader.

Test Plan:
- Reset mid-load:
  - Stimulus: load_start, send 5 bytes, assert reset.
  - Response: all outputs 0 asynchronously; state IDLE; in_ready=0; written bytes remain readable.
- Good load:
  - Stimulus: load_start, then bytes 0x00..0x0F with in_valid held high, then checksum 0x88 (sum of 0..15 = 0x78; 0x78+0x88 = 0x100).
  - Response: core_run=1, done=1, err=0 one cycle after the last edge; rd_addr=5 gives rd_data=0x05.
- Bad checksum:
  - Stimulus: same 16 bytes, checksum 0x87.
  - Response: err=1, core_run=0, in_ready=0. A following load_start clears err and sets busy=1.
- Restart and backpressure:
  - Stimulus: load_start, 3 bytes, then load_start with in_valid=1 and data 0xAA in the same cycle; then a full program with in_valid toggling every other cycle.
  - Response: 0xAA not written; memory matches the second program word for word; done=1.
- Reload from RUN:
  - Stimulus: in RUN, pulse load_start.
  - Response: core_run=0 and done=0 on the next edge; busy=1.
- No checksum (CHECKSUM_EN=0):
  - Stimulus: load 16 bytes.
  - Response: core_run=1 after the 16th transfer; in_ready=0 from then on.
